// File: rtl/tcam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tcam_pkg
//  Description : Shared geometry constants and controller state encoding for
//                the SRAM-based TCAM access front-end.
//  Revision    : 1.0 - initial release
// ============================================================================
package tcam_pkg;

    localparam int TCAM_KEY_W   = 28;   // search key width (also macro addr width)
    localparam int TCAM_DATA_W  = 32;   // SRAM word width, one bit per rule
    localparam int TCAM_WADDR_W = 9;    // {block select, word address}
    localparam int TCAM_PMA_W   = 6;    // priority-match address width
    localparam int TCAM_WORDS   = 512;  // SRAM words cleared by the init sweep
    localparam int TCAM_WMASK_W = TCAM_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tcam_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/tcam_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tcam_rsp_fifo
//  Description : Tracks issued searches through the macro read latency and
//                queues the captured priority-match results with their tags.
//                A READ_LAT+1 stage valid/tag shift register follows each
//                search from issue to the edge where the macro result is
//                valid; that edge pushes {pma, tag} into the response FIFO.
//  Ports       : clk, rst_n        clock, async active-low reset
//                i_issue_valid/tag search accepted this cycle and its tag
//                i_pma             raw macro result
//                i_pop             consumer ready (qualified internally)
//                o_rsp_valid/pma/tag  head of the response queue
//                o_count           FIFO occupancy
//                o_inflight        searches issued but not yet captured
//  Revision    : 1.0 - initial release
// ============================================================================
module tcam_rsp_fifo
    import tcam_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4,
    parameter int READ_LAT  = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_issue_valid,
    input  logic [TAG_W-1:0]                    i_issue_tag,
    input  logic [TCAM_PMA_W-1:0]               i_pma,
    input  logic                                i_pop,
    output logic                                o_rsp_valid,
    output logic [TCAM_PMA_W-1:0]               o_rsp_pma,
    output logic [TAG_W-1:0]                    o_rsp_tag,
    output logic [$clog2(RSP_DEPTH+1)-1:0]      o_count,
    output logic [$clog2(RSP_DEPTH+1)-1:0]      o_inflight
);

    localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int c_ENT_W = TCAM_PMA_W + TAG_W;
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(RSP_DEPTH - 1);

    logic [READ_LAT:0]   r_stg_vld;
    logic [TAG_W-1:0]    r_stg_tag [READ_LAT+1];
    logic [c_ENT_W-1:0]  r_mem     [RSP_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_inflight;
    logic                w_push;
    logic                w_pop;

    // The last stage is valid exactly on the edge where the macro output
    // belongs to that search, so it doubles as the FIFO push strobe.
    assign w_push = r_stg_vld[READ_LAT];
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_vld <= '0;
            for (int s = 0; s <= READ_LAT; s++) begin
                r_stg_tag[s] <= '0;
            end
        end else begin
            r_stg_vld[0] <= i_issue_valid;
            r_stg_tag[0] <= i_issue_tag;
            for (int s = 1; s <= READ_LAT; s++) begin
                r_stg_vld[s] <= r_stg_vld[s-1];
                r_stg_tag[s] <= r_stg_tag[s-1];
            end
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int s = 0; s <= READ_LAT; s++) begin
            w_inflight = w_inflight + c_CNT_W'(r_stg_vld[s]);
        end
    end

    // Storage needs no reset: an entry is only visible once r_count covers it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_pma, r_stg_tag[READ_LAT]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rsp_valid = (r_count != '0);
    assign o_rsp_pma   = r_mem[r_rd_ptr][c_ENT_W-1:TAG_W];
    assign o_rsp_tag   = r_mem[r_rd_ptr][TAG_W-1:0];
    assign o_count     = r_count;
    assign o_inflight  = w_inflight;

endmodule
`default_nettype wire

// File: rtl/tcam_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tcam_access_ctrl
//  Description : Front-end for the 32x28 SRAM-based TCAM macro wrapper.
//                Clears all SRAM words after reset or on request, then
//                arbitrates rule writes (priority) and tagged searches onto
//                the registered macro pins and returns search results in
//                issue order through a credit-limited response FIFO.
//  Ports       : in_clk/in_rst_n         clock, async active-low reset
//                in_init_req/out_init_busy  clear-sweep request / status
//                in_wr_*/out_wr_ready    rule-word write channel
//                in_sq_*/out_sq_ready    search request channel
//                out_rsp_*/in_rsp_ready  search response channel
//                out_tcam_*/in_tcam_pma  macro pins
//  Revision    : 1.0 - initial release
// ============================================================================
module tcam_access_ctrl
    import tcam_pkg::*;
#(
    parameter int READ_LAT  = 1,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic                     in_clk,
    input  logic                     in_rst_n,
    input  logic                     in_init_req,
    output logic                     out_init_busy,
    input  logic                     in_wr_valid,
    output logic                     out_wr_ready,
    input  logic [TCAM_WADDR_W-1:0]  in_wr_addr,
    input  logic [TCAM_DATA_W-1:0]   in_wr_data,
    input  logic [TCAM_WMASK_W-1:0]  in_wr_mask,
    input  logic                     in_sq_valid,
    output logic                     out_sq_ready,
    input  logic [TCAM_KEY_W-1:0]    in_sq_key,
    input  logic [TAG_W-1:0]         in_sq_tag,
    output logic                     out_rsp_valid,
    input  logic                     in_rsp_ready,
    output logic [TCAM_PMA_W-1:0]    out_rsp_pma,
    output logic                     out_rsp_hit,
    output logic [TAG_W-1:0]         out_rsp_tag,
    output logic                     out_tcam_csb,
    output logic                     out_tcam_web,
    output logic [TCAM_WMASK_W-1:0]  out_tcam_wmask,
    output logic [TCAM_KEY_W-1:0]    out_tcam_addr,
    output logic [TCAM_DATA_W-1:0]   out_tcam_wdata,
    input  logic [TCAM_PMA_W-1:0]    in_tcam_pma
);

    localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [TCAM_WADDR_W-1:0] c_CNT_LAST = TCAM_WADDR_W'(TCAM_WORDS - 1);

    tcam_ctrl_state_e          r_state, w_state_nxt;
    logic [TCAM_WADDR_W-1:0]   r_init_cnt, w_init_cnt_nxt;
    logic                      r_csb, w_csb_nxt;
    logic                      r_web, w_web_nxt;
    logic [TCAM_WMASK_W-1:0]   r_wmask, w_wmask_nxt;
    logic [TCAM_KEY_W-1:0]     r_addr, w_addr_nxt;
    logic [TCAM_DATA_W-1:0]    r_wdata, w_wdata_nxt;
    logic [c_CNT_W-1:0]        w_inflight;
    logic [c_CNT_W-1:0]        w_fifo_count;
    logic                      w_credit_ok;
    logic                      w_wr_ready;
    logic                      w_sq_ready;
    logic                      w_wr_fire;
    logic                      w_sq_fire;

    // Searches in the pipe plus results already queued may never exceed the
    // FIFO depth, so every issued search is guaranteed a slot on arrival.
    assign w_credit_ok = ({1'b0, w_inflight} + {1'b0, w_fifo_count}) < (c_CNT_W+1)'(RSP_DEPTH);
    assign w_wr_ready  = (r_state == ST_RUN);
    assign w_sq_ready  = (r_state == ST_RUN) && !in_wr_valid && w_credit_ok;
    assign w_wr_fire   = in_wr_valid && w_wr_ready;
    assign w_sq_fire   = in_sq_valid && w_sq_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_csb_nxt      = 1'b1;
        w_web_nxt      = 1'b1;
        w_wmask_nxt    = '0;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        case (r_state)
            ST_INIT: begin
                w_csb_nxt   = 1'b0;
                w_web_nxt   = 1'b0;
                w_wmask_nxt = '1;
                w_wdata_nxt = '0;
                w_addr_nxt  = TCAM_KEY_W'(r_init_cnt);
                if (r_init_cnt == c_CNT_LAST) begin
                    w_state_nxt    = ST_RUN;
                    w_init_cnt_nxt = '0;  // re-armed for the next sweep
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (w_wr_fire) begin
                    w_csb_nxt   = 1'b0;
                    w_web_nxt   = 1'b0;
                    w_wmask_nxt = in_wr_mask;
                    w_addr_nxt  = TCAM_KEY_W'(in_wr_addr);
                    w_wdata_nxt = in_wr_data;
                end else if (w_sq_fire) begin
                    w_csb_nxt   = 1'b0;
                    w_addr_nxt  = in_sq_key;
                end
                if (in_init_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((w_inflight == '0) && (w_fifo_count == '0)) begin
                    w_state_nxt = ST_INIT;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_csb      <= 1'b1;
            r_web      <= 1'b1;
            r_wmask    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_csb      <= w_csb_nxt;
            r_web      <= w_web_nxt;
            r_wmask    <= w_wmask_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

    tcam_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH),
        .TAG_W     (TAG_W),
        .READ_LAT  (READ_LAT)
    ) u_rsp_fifo (
        .clk           (in_clk),
        .rst_n         (in_rst_n),
        .i_issue_valid (w_sq_fire),
        .i_issue_tag   (in_sq_tag),
        .i_pma         (in_tcam_pma),
        .i_pop         (in_rsp_ready),
        .o_rsp_valid   (out_rsp_valid),
        .o_rsp_pma     (out_rsp_pma),
        .o_rsp_tag     (out_rsp_tag),
        .o_count       (w_fifo_count),
        .o_inflight    (w_inflight)
    );

    assign out_init_busy  = (r_state != ST_RUN);
    assign out_wr_ready   = w_wr_ready;
    assign out_sq_ready   = w_sq_ready;
    assign out_rsp_hit    = |out_rsp_pma;
    assign out_tcam_csb   = r_csb;
    assign out_tcam_web   = r_web;
    assign out_tcam_wmask = r_wmask;
    assign out_tcam_addr  = r_addr;
    assign out_tcam_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_tcam_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tcam_access_ctrl
//  Description : Directed self-checking bench for tcam_access_ctrl. A small
//                behavioural macro (4 key chunks of 7 bits, each indexing a
//                block of 128 rule words; the AND of the four words gives the
//                rule match vector, lowest rule wins) answers searches with
//                one cycle of read latency. Expected responses are queued
//                when a search is accepted and compared as they leave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tcam_access_ctrl;

    localparam int READ_LAT  = 1;
    localparam int RSP_DEPTH = 4;
    localparam int TAG_W     = 4;
    localparam logic [27:0] c_K2 = {7'h33, 7'h22, 7'h11, 7'h05};
    localparam logic [27:0] c_K3 = {7'h01, 21'h0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_req, init_busy;
    logic        wr_valid, wr_ready;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        sq_valid, sq_ready;
    logic [27:0] sq_key;
    logic [3:0]  sq_tag;
    logic        rsp_valid, rsp_ready, rsp_hit;
    logic [5:0]  rsp_pma;
    logic [3:0]  rsp_tag;
    logic        tcam_csb, tcam_web;
    logic [3:0]  tcam_wmask;
    logic [27:0] tcam_addr;
    logic [31:0] tcam_wdata;
    logic [5:0]  tcam_pma;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [5:0] pma;
        logic [3:0] tag;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem [512];
    logic [5:0]  mac_pma;

    always #5 clk = ~clk;

    tcam_access_ctrl #(
        .READ_LAT  (READ_LAT),
        .RSP_DEPTH (RSP_DEPTH),
        .TAG_W     (TAG_W)
    ) dut (
        .in_clk         (clk),
        .in_rst_n       (rst_n),
        .in_init_req    (init_req),
        .out_init_busy  (init_busy),
        .in_wr_valid    (wr_valid),
        .out_wr_ready   (wr_ready),
        .in_wr_addr     (wr_addr),
        .in_wr_data     (wr_data),
        .in_wr_mask     (wr_mask),
        .in_sq_valid    (sq_valid),
        .out_sq_ready   (sq_ready),
        .in_sq_key      (sq_key),
        .in_sq_tag      (sq_tag),
        .out_rsp_valid  (rsp_valid),
        .in_rsp_ready   (rsp_ready),
        .out_rsp_pma    (rsp_pma),
        .out_rsp_hit    (rsp_hit),
        .out_rsp_tag    (rsp_tag),
        .out_tcam_csb   (tcam_csb),
        .out_tcam_web   (tcam_web),
        .out_tcam_wmask (tcam_wmask),
        .out_tcam_addr  (tcam_addr),
        .out_tcam_wdata (tcam_wdata),
        .in_tcam_pma    (tcam_pma)
    );

    // ---------------- behavioural macro ----------------
    function automatic logic [5:0] macro_match(input logic [27:0] key);
        logic [31:0] m;
        m = mem[{2'd0, key[6:0]}] & mem[{2'd1, key[13:7]}]
          & mem[{2'd2, key[20:14]}] & mem[{2'd3, key[27:21]}];
        for (int r = 0; r < 32; r++) begin
            if (m[r]) return 6'(r + 1);
        end
        return 6'd0;
    endfunction

    always @(posedge clk) begin
        if (!tcam_csb) begin
            if (!tcam_web) begin
                for (int b = 0; b < 4; b++) begin
                    if (tcam_wmask[b]) mem[tcam_addr[8:0]][b*8 +: 8] <= tcam_wdata[b*8 +: 8];
                end
            end else begin
                mac_pma <= macro_match(tcam_addr);
            end
        end
    end
    assign tcam_pma = mac_pma;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, 128'({tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata,
                       rsp_valid, wr_ready, sq_ready, init_busy}),
                 128'({1'b1, 1'b1, 4'h0, 28'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
    endtask

    // Response scoreboard: every valid cycle is compared against the queue
    // head, so stalled outputs are checked for stability as well.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_spurious", 128'(rsp_valid), 128'd0);
            end else begin
                chk("rsp_fields", 128'({rsp_pma, rsp_hit, rsp_tag}),
                    128'({exp_q[0].pma, (exp_q[0].pma != 6'd0), exp_q[0].tag}));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        logic ok;
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wr_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("wr_accept", 128'(ok), 128'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_search(input logic [27:0] key, input logic [3:0] tag,
                             input logic [5:0] exp_pma, input bit check_lat);
        logic ok;
        @(posedge clk); #1;
        sq_valid = 1'b1; sq_key = key; sq_tag = tag;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sq_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("sq_accept", 128'(ok), 128'd1);
        @(posedge clk);
        exp_q.push_back('{exp_pma, tag});
        #1 sq_valid = 1'b0;
        if (check_lat) begin
            @(negedge clk);
            @(negedge clk);
            chk("lat_not_early", 128'(rsp_valid), 128'd0);
            @(negedge clk);
            chk("lat_exact", 128'(rsp_valid), 128'd1);
        end
    endtask

    task automatic wait_drain(input int bound);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        chk("drain_done", 128'(ok), 128'd1);
    endtask

    task automatic wait_sweep_start(input int bound);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!tcam_csb && !tcam_web) begin ok = 1'b1; break; end
        end
        chk("sweep_start", 128'(ok), 128'd1);
    endtask

    // Called with the first sweep write already on the pins.
    task automatic check_sweep(input int pulse_at);
        for (int i = 0; i < 512; i++) begin
            if (i != 0) @(negedge clk);
            chk("sweep_pins", 128'({tcam_csb, tcam_web, tcam_wmask, tcam_wdata, tcam_addr}),
                              128'({1'b0, 1'b0, 4'hF, 32'h0, 28'(i)}));
            chk("sweep_status", 128'({wr_ready, sq_ready, init_busy}),
                                128'((i < 511) ? 3'b001 : 3'b110));
            if (pulse_at >= 0 && i == pulse_at) begin
                @(posedge clk); #1 init_req = 1'b1;
            end
            if (pulse_at >= 0 && i == pulse_at + 1) begin
                @(posedge clk); #1 init_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("post_sweep", 128'({init_busy, wr_ready, tcam_csb}), 128'(3'b011));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int idx;
        rst_n = 1'b0; init_req = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        sq_valid = 1'b0; sq_key = '0; sq_tag = '0; rsp_ready = 1'b1;

        // Reset values, then the full post-reset sweep.
        repeat (3) @(negedge clk);
        chk_reset("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_sweep(-1);

        // Rule 0 matches key 0 in every chunk.
        do_write(9'h000, 32'h1, 4'hF);
        do_write(9'h080, 32'h1, 4'hF);
        do_write(9'h100, 32'h1, 4'hF);
        do_write(9'h180, 32'h1, 4'hF);
        do_search(28'h0, 4'd3, 6'd1, 1'b1);
        wait_drain(20);

        // Rules 2 and 4 match K2; lowest index wins. K3 misses.
        do_write(9'h005, 32'h14, 4'hF);
        do_write(9'h091, 32'h14, 4'hF);
        do_write(9'h122, 32'h14, 4'hF);
        do_write(9'h1B3, 32'h14, 4'hF);
        do_search(c_K2, 4'd4, 6'd3, 1'b0);
        do_search(c_K3, 4'd2, 6'd0, 1'b0);
        wait_drain(20);

        // Byte mask: only byte 0 is written.
        do_write(9'h005, 32'hFFFF_FF00, 4'b0001);
        do_search(c_K2, 4'd1, 6'd0, 1'b0);
        do_write(9'h005, 32'hFFFF_FF10, 4'b0001);
        do_search(c_K2, 4'd8, 6'd5, 1'b0);
        wait_drain(20);

        // Write/search collision: write goes first.
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_addr = 9'h000; wr_data = 32'h1; wr_mask = 4'hF;
        sq_valid = 1'b1; sq_key = 28'h0; sq_tag = 4'd5;
        @(negedge clk);
        chk("coll_ready", 128'({wr_ready, sq_ready}), 128'(2'b10));
        @(posedge clk); #1 wr_valid = 1'b0;
        @(negedge clk);
        chk("coll_write_pins", 128'({tcam_csb, tcam_web, tcam_wmask, tcam_addr, tcam_wdata}),
                               128'({1'b0, 1'b0, 4'hF, 28'h0, 32'h1}));
        chk("coll_sq_ready", 128'(sq_ready), 128'd1);
        @(posedge clk);
        exp_q.push_back('{6'd1, 4'd5});
        #1 sq_valid = 1'b0;
        @(negedge clk);
        chk("coll_search_pins", 128'({tcam_csb, tcam_web, tcam_addr}), 128'({1'b0, 1'b1, 28'h0}));
        wait_drain(20);

        // Credit limit: 6 back-to-back searches, responses stalled.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        acc = 0; idx = 0;
        sq_valid = 1'b1; sq_key = 28'h0; sq_tag = 4'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sq_ready && idx < 6) begin
                @(posedge clk);
                exp_q.push_back('{(idx % 2 == 1) ? 6'd5 : 6'd1, 4'(idx)});
                acc++; idx++;
                #1 sq_key = (idx % 2 == 1) ? c_K2 : 28'h0; sq_tag = 4'(idx);
            end else begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        chk("stall_accepts", 128'(acc), 128'd4);
        chk("stall_sq_ready", 128'(sq_ready), 128'd0);
        @(posedge clk); #1 sq_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_drain(20);

        // init_req with two searches outstanding.
        @(posedge clk); #1 rsp_ready = 1'b0;
        do_search(28'h0, 4'd6, 6'd1, 1'b0);
        do_search(28'h0, 4'd7, 6'd1, 1'b0);
        @(posedge clk); #1 init_req = 1'b1;
        @(posedge clk); #1 init_req = 1'b0;
        @(negedge clk);
        chk("drain_status", 128'({wr_ready, sq_ready, init_busy}), 128'(3'b001));
        repeat (4) @(negedge clk);
        chk("drain_idle", 128'({tcam_csb, rsp_valid}), 128'(2'b11));
        @(posedge clk); #1 init_req = 1'b1;
        @(posedge clk); #1 init_req = 1'b0;
        rsp_ready = 1'b1;
        wait_sweep_start(50);
        chk("drained_first", 128'(exp_q.size()), 128'd0);
        check_sweep(100);
        do_search(28'h0, 4'd9, 6'd0, 1'b0);
        do_search(c_K2, 4'd10, 6'd0, 1'b0);
        wait_drain(20);

        // Async reset in the middle of a sweep.
        @(posedge clk); #1 init_req = 1'b1;
        @(posedge clk); #1 init_req = 1'b0;
        wait_sweep_start(20);
        for (int i = 0; i <= 200; i++) begin
            if (i != 0) @(negedge clk);
            chk("sweep2_addr", 128'({tcam_csb, tcam_web, tcam_addr}), 128'({1'b0, 1'b0, 28'(i)}));
        end
        #1 rst_n = 1'b0;
        #1 chk_reset("reset_mid_sweep");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_sweep(-1);
        do_search(28'h0, 4'd11, 6'd0, 1'b0);
        wait_drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
